// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - single-outstanding memory responder with modelled latency
//
// Purpose: serves CPU fetch/load/store requests from an internal synchronous,
// word-addressed RAM. It takes one request at a time and waits LATENCY cycles
// before it answers.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_write, req_addr, req_wdata carry the request
//   rsp_valid/rsp_ready   response handshake; rsp_rdata, rsp_err carry the response
//   busy                  high whenever the responder is not idle
module cpu_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_acc_write;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_in_range;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_idx;

    assign w_accept = req_valid && req_ready;

    // With zero latency the RAM is accessed on the accepting edge itself, so
    // the access uses the live request inputs. In every other case it uses the
    // latched copy.
    assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_in_range  = {1'b0, w_acc_addr} < DEPTH_L;
    assign w_idx       = w_acc_addr[IDX_W-1:0];
    // A reset on the commit edge wins, so a dropped write never lands.
    assign w_mem_we    = reset && w_enter_resp && w_acc_write && w_in_range;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_resp = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response fields are captured once on RESP entry and then held
            // until the response handshake completes.
            if (w_enter_resp) begin
                r_err   <= !w_in_range;
                r_rdata <= (w_in_range && !w_acc_write) ? r_mem[w_idx] : '0;
            end
        end
    end

    // The RAM is deliberately left out of reset so that its contents survive it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - scoreboard bench for cpu_mem_responder
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [7:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    typedef struct {
        int          u;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever a response handshake is
    // about to happen on any instance.
    always begin
        @(negedge clk);
        #2;
        for (int u = 0; u < 3; u++) begin
            if (reset && rsp_valid[u] && rsp_ready[u]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: instance %0d rdata 0x%0h with empty scoreboard", u, rsp_rdata[u]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_instance", u, mon_e.u);
                    check("rsp_rdata", rsp_rdata[u], mon_e.rdata);
                    check("rsp_err", rsp_err[u], mon_e.err);
                end
            end
        end
    end

    task automatic issue(input int u, input bit w, input logic [7:0] a, input logic [15:0] d,
                         input logic [15:0] er, input bit ee, input int lat);
        int c;
        exp_q.push_back('{u, er, ee});
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        c = 0;
        while (!req_ready[u] && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!req_ready[u]) check("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid[u] = 1'b0;
        c = 1;
        while (!rsp_valid[u] && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("rsp_latency", c, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int acc1;
        int acc2;
        bit seen;
        reset = 1'b0;
        for (int u = 0; u < 3; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            rsp_ready[u] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("reset_req_ready", req_ready[u], 1);
            check("reset_rsp_valid", rsp_valid[u], 0);
            check("reset_rsp_rdata", rsp_rdata[u], 0);
            check("reset_rsp_err", rsp_err[u], 0);
            check("reset_busy", busy[u], 0);
        end

        // Write then read, latency 2
        issue(0, 1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0, 3);
        issue(0, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 3);

        // Response backpressure
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid[0], 1);
            check("bp_rsp_rdata", rsp_rdata[0], 16'hBEEF);
            check("bp_req_ready", req_ready[0], 0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_req_ready", req_ready[0], 1);
        check("bp_release_rsp_valid", rsp_valid[0], 0);
        check("bp_release_busy", busy[0], 0);

        // Out of range (DEPTH=128)
        issue(0, 1'b1, 8'h00, 16'h0055, 16'h0000, 1'b0, 3);
        issue(0, 1'b1, 8'h80, 16'h1234, 16'h0000, 1'b1, 3);
        issue(0, 1'b0, 8'h00, 16'h0000, 16'h0055, 1'b0, 3);

        // Zero latency: preload, then back-to-back reads with req_valid held
        issue(1, 1'b1, 8'h05, 16'h1111, 16'h0000, 1'b0, 1);
        issue(1, 1'b1, 8'h06, 16'h2222, 16'h0000, 1'b0, 1);
        @(negedge clk);
        exp_q.push_back('{1, 16'h1111, 1'b0});
        exp_q.push_back('{1, 16'h2222, 1'b0});
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 8'h05;
        c = 0;
        while (!req_ready[1] && c < 20) begin
            @(negedge clk);
            c++;
        end
        acc1 = cyc;
        @(negedge clk);
        check("b2b_first_rsp_valid", rsp_valid[1], 1);
        req_addr[1] = 8'h06;
        @(negedge clk);
        c = 0;
        while (!req_ready[1] && c < 20) begin
            @(negedge clk);
            c++;
        end
        acc2 = cyc;
        check("b2b_accept_spacing", acc2 - acc1, 2);
        @(negedge clk);
        check("b2b_second_rsp_valid", rsp_valid[1], 1);
        req_valid[1] = 1'b0;

        // Reset in the middle of WAIT, latency 3
        issue(2, 1'b1, 8'h07, 16'h0111, 16'h0000, 1'b0, 4);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 8'h07;
        req_wdata[2] = 16'h0AAA;
        c = 0;
        while (!req_ready[2] && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("midwait_busy", busy[2], 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midwait_after_reset_busy", busy[2], 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2]) seen = 1'b1;
            @(negedge clk);
        end
        check("midwait_no_response", seen, 0);
        issue(2, 1'b0, 8'h07, 16'h0000, 16'h0111, 1'b0, 4);

        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
